status_branch_unit: RTL and testbench

Consumes the status flags (Sign, Zero, Carry, Parity, Overflow) produced by the 16-bit ALU in EX and holds them in an architectural status register. It resolves conditional branches against that register and forwards same-cycle flag updates. It returns a registered taken/target result to the fetch stage over a valid/ready handshake. It sits between EX (flag writer) and IF/ID (branch consumer).

---
 rtl/status_branch_unit_pkg.sv | 50 +++++
 rtl/status_branch_unit_cond_eval.sv | 38 +++
 rtl/status_branch_unit.sv | 112 +++++++++++
 tb/tb_status_branch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/status_branch_unit_pkg.sv
// Shared types for the status register and the branch condition codes.
// Also imported by the decoder, so the encodings here are architectural.
package status_branch_unit_pkg;

    localparam int unsigned STATUS_W = 5;

    // Branch condition codes, as carried in the instruction's condition field.
    typedef enum logic [3:0] {
        CondEq = 4'd0,
        CondNe = 4'd1,
        CondCs = 4'd2,
        CondCc = 4'd3,
        CondMi = 4'd4,
        CondPl = 4'd5,
        CondVs = 4'd6,
        CondVc = 4'd7,
        CondPe = 4'd8,
        CondPo = 4'd9,
        CondGe = 4'd10,
        CondLt = 4'd11,
        CondGt = 4'd12,
        CondLe = 4'd13,
        CondAl = 4'd14,
        CondNv = 4'd15
    } cond_e;

    // Field order gives the {S,Z,C,P,V} bit layout seen on the status port.
    typedef struct packed {
        logic sign;
        logic zero;
        logic carry;
        logic parity;
        logic ovf;
    } status_t;

    // Flags of a zero result: zero set, even parity, everything else clear.
    localparam status_t STATUS_RESET = '{
        sign:   1'b0,
        zero:   1'b1,
        carry:  1'b0,
        parity: 1'b1,
        ovf:    1'b0
    };

    // Signed less-than after a compare: sign disagrees with overflow.
    function automatic logic signed_lt(status_t f);
        return f.sign ^ f.ovf;
    endfunction

endpackage

// File: rtl/status_branch_unit_cond_eval.sv
// Purely combinational branch condition evaluation against a set of flags.
module status_branch_unit_cond_eval
    import status_branch_unit_pkg::*;
(
    input  status_t flags_i,
    input  cond_e   cond_i,
    output logic    taken_o
);

    logic lt;

    assign lt = signed_lt(flags_i);

    // Map condition code to taken using the supplied flags.
    always_comb begin
        taken_o = 1'b0;
        unique case (cond_i)
            CondEq: taken_o = flags_i.zero;
            CondNe: taken_o = ~flags_i.zero;
            CondCs: taken_o = flags_i.carry;
            CondCc: taken_o = ~flags_i.carry;
            CondMi: taken_o = flags_i.sign;
            CondPl: taken_o = ~flags_i.sign;
            CondVs: taken_o = flags_i.ovf;
            CondVc: taken_o = ~flags_i.ovf;
            CondPe: taken_o = flags_i.parity;
            CondPo: taken_o = ~flags_i.parity;
            CondGe: taken_o = ~lt;
            CondLt: taken_o = lt;
            CondGt: taken_o = ~flags_i.zero & ~lt;
            CondLe: taken_o = flags_i.zero | lt;
            CondAl: taken_o = 1'b1;
            CondNv: taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_branch_unit.sv
// Architectural status register plus branch resolution. Flags written by EX
// are bypassed into same-cycle branch evaluation; the taken/target result is
// held in a single output register handed to fetch over valid/ready.
module status_branch_unit
    import status_branch_unit_pkg::*;
#(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned COND_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_we,
    input  logic              flag_sign,
    input  logic              flag_zero,
    input  logic              flag_carry,
    input  logic              flag_parity,
    input  logic              flag_ovf,
    input  logic              flag_busy,
    input  logic              flush,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [COND_W-1:0] br_cond,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [PC_W-1:0]   br_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic [PC_W-1:0]   out_target,
    output logic [4:0]        status
);

    status_t         status_q, status_d;
    status_t         flags_in;
    status_t         flags_eff;
    logic            valid_q, valid_d;
    logic            taken_q, taken_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            cond_taken;
    logic            accept;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_branch;

    assign flags_in = '{
        sign:   flag_sign,
        zero:   flag_zero,
        carry:  flag_carry,
        parity: flag_parity,
        ovf:    flag_ovf
    };

    // A write in flight this cycle is visible to the branch evaluated now.
    assign flags_eff = flag_we ? flags_in : status_q;

    status_branch_unit_cond_eval u_cond_eval (
        .flags_i (flags_eff),
        .cond_i  (cond_e'(br_cond)),
        .taken_o (cond_taken)
    );

    // Word-addressed; both sums wrap modulo 2^PC_W by truncation.
    assign pc_next   = br_pc + PC_W'(1);
    assign pc_branch = pc_next + br_offset;

    // The output slot can take a new result when empty or draining this cycle.
    assign br_ready = ~flag_busy & ~flush & (~valid_q | out_ready);
    assign accept   = br_valid & br_ready;

    // Status register: loads on flag writes only; flush has no effect here.
    always_comb begin
        status_d = status_q;
        if (flag_we) begin
            status_d = flags_in;
        end
    end

    // Result register next-state: load on accept, drop on flush or handshake.
    always_comb begin
        valid_d  = valid_q;
        taken_d  = taken_q;
        target_d = target_q;
        if (accept) begin
            valid_d  = 1'b1;
            taken_d  = cond_taken;
            target_d = cond_taken ? pc_branch : pc_next;
        end else if (flush) begin
            valid_d = 1'b0;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= STATUS_RESET;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            status_q <= status_d;
            valid_q  <= valid_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_taken  = taken_q;
    assign out_target = target_q;
    assign status     = status_q;

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed bench for status_branch_unit. Expected results are queued when a
// branch is accepted and checked by an independent monitor on handshake.
module tb_status_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_we, flag_sign, flag_zero, flag_carry, flag_parity, flag_ovf;
    logic        flag_busy, flush;
    logic        br_valid, br_ready;
    logic [3:0]  br_cond;
    logic [15:0] br_pc, br_offset;
    logic        out_valid, out_ready, out_taken;
    logic [15:0] out_target;
    logic [4:0]  status;

    int n_vec  = 0;
    int n_miss = 0;

    logic [16:0] exp_q[$];

    localparam logic [3:0] EQ = 4'd0, NE = 4'd1, CS = 4'd2, MI = 4'd4, PO = 4'd9;
    localparam logic [3:0] GE = 4'd10, LT = 4'd11, GT = 4'd12, LE = 4'd13;
    localparam logic [3:0] AL = 4'd14, NV = 4'd15;

    status_branch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flag_we     (flag_we),
        .flag_sign   (flag_sign),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry),
        .flag_parity (flag_parity),
        .flag_ovf    (flag_ovf),
        .flag_busy   (flag_busy),
        .flush       (flush),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_cond     (br_cond),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_taken   (out_taken),
        .out_target  (out_target),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got taken=%b target=%h, want none",
                         out_taken, out_target);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("result", {15'd0, out_taken, out_target}, {15'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic s, z, c, p, v);
        flag_sign = s; flag_zero = z; flag_carry = c; flag_parity = p; flag_ovf = v;
    endtask

    task automatic write_flags(input logic s, z, c, p, v);
        set_flags(s, z, c, p, v);
        flag_we = 1'b1;
        step();
        flag_we = 1'b0;
    endtask

    // Present a branch until accepted; queue its expected result if wanted.
    task automatic send(input logic [3:0] cond, input logic [15:0] pc, input logic [15:0] off,
                        input logic exp_taken, input logic [15:0] exp_target,
                        input logic queue_it);
        bit acc = 0;
        br_valid = 1'b1; br_cond = cond; br_pc = pc; br_offset = off;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (br_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (queue_it) begin
            exp_q.push_back({exp_taken, exp_target});
        end
        step();
        br_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] st_saved;
        rst_n = 1'b0; flag_we = 1'b0; flag_busy = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        br_valid = 1'b1; br_cond = AL; br_pc = 16'h1234; br_offset = 16'h0001;

        // Reset with a request asserted.
        step();
        @(negedge clk);
        check("reset_status", {27'd0, status}, {27'd0, 5'b01010});
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        step();
        rst_n = 1'b1; br_valid = 1'b0;
        check("reset_taken", {31'd0, out_taken}, 32'd0);
        check("reset_target", {16'd0, out_target}, 32'd0);

        send(EQ, 16'h0010, 16'h0004, 1'b1, 16'h0015, 1'b1);

        // Same-cycle flag write bypassed into an NE branch.
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        flag_we = 1'b1;
        send(NE, 16'h0100, 16'hFFF0, 1'b1, 16'h00F1, 1'b1);
        flag_we = 1'b0;
        check("bypass_status", {27'd0, status}, {27'd0, 5'b00000});

        // Signed compares.
        write_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("status_sv", {27'd0, status}, {27'd0, 5'b10011});
        send(GE, 16'h0200, 16'h0010, 1'b1, 16'h0211, 1'b1);
        send(LT, 16'h0300, 16'h0010, 1'b0, 16'h0301, 1'b1);
        write_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send(LE, 16'h0400, 16'h0020, 1'b1, 16'h0421, 1'b1);
        send(GT, 16'h0500, 16'h0020, 1'b0, 16'h0501, 1'b1);
        send(CS, 16'h0600, 16'h0001, 1'b1, 16'h0602, 1'b1);
        send(PO, 16'h0700, 16'hFFFF, 1'b1, 16'h0700, 1'b1);

        // Backpressure with a second request waiting.
        step(); step();
        out_ready = 1'b0;
        send(AL, 16'h1000, 16'h0100, 1'b1, 16'h1101, 1'b1);
        br_valid = 1'b1; br_cond = MI; br_pc = 16'h2000; br_offset = 16'h0008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", {31'd0, br_ready}, 32'd0);
            check("bp_hold", {15'd0, out_valid, out_target}, {15'd0, 1'b1, 16'h1101});
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, br_ready}, 32'd1);
        if (br_ready) exp_q.push_back({1'b1, 16'h2009});
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("bp_no_bubble", {15'd0, out_valid, out_target}, {15'd0, 1'b1, 16'h2009});
        step();

        // Wrap-around targets.
        send(AL, 16'hFFFE, 16'h0003, 1'b1, 16'h0002, 1'b1);
        send(NV, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 1'b1);
        step(); step();

        // Flush drops a stalled result and a same-cycle request.
        out_ready = 1'b0;
        send(EQ, 16'h3000, 16'h0010, 1'b0, 16'h3001, 1'b0);
        st_saved = status;
        flush = 1'b1;
        br_valid = 1'b1; br_cond = AL; br_pc = 16'h5000; br_offset = 16'h0001;
        @(negedge clk);
        check("flush_ready", {31'd0, br_ready}, 32'd0);
        step();
        flush = 1'b0; br_valid = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_status", {27'd0, status}, {27'd0, st_saved});
        out_ready = 1'b1;

        // Busy stall, with a flag write landing during the stall.
        flag_busy = 1'b1;
        br_valid = 1'b1; br_cond = EQ; br_pc = 16'h4000; br_offset = 16'h0040;
        set_flags(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        flag_we = 1'b1;
        @(negedge clk);
        check("busy_ready0", {31'd0, br_ready}, 32'd0);
        step();
        flag_we = 1'b0;
        @(negedge clk);
        check("busy_ready1", {31'd0, br_ready}, 32'd0);
        step();
        flag_busy = 1'b0;
        check("busy_status", {27'd0, status}, {27'd0, 5'b01010});
        send(EQ, 16'h4000, 16'h0040, 1'b1, 16'h4041, 1'b1);

        repeat (4) step();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
